// File: rtl/u_mem_arb_pkg.sv
// Shared types for the memory arbiter: transaction owner and the per-transaction
// tag kept in the in-order owner FIFO.
package riscv_pkg;

   typedef enum logic {OWN_IFU = 1'b0, OWN_LSU = 1'b1} mem_owner_e;

   typedef struct packed {
      mem_owner_e own;
      logic       kill;
   } mem_tag_t;

   localparam logic [3:0] IFU_RE = 4'hF;

endpackage

// File: rtl/u_mem_arb_owner_fifo.sv
// In-order FIFO of owner tags for accepted-but-unanswered memory transactions.
// kill_ifu marks every IFU tag stale; a tag pushed in the same cycle stays live.
module u_owner_fifo
   import riscv_pkg::*;
#(
   parameter int MAX_OUTS = 2
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic                             push,
   input  mem_tag_t                         push_tag,
   input  logic                             pop,
   input  logic                             kill_ifu,
   output mem_tag_t                         head,
   output logic [$clog2(MAX_OUTS+1)-1:0]    cnt
);

   localparam int PW = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
   localparam int CW = $clog2(MAX_OUTS + 1);

   mem_tag_t        tags [MAX_OUTS];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUTS - 1)) ? '0 : p + 1'b1;
   endfunction

   // Entries outside the occupied window may also get kill set; a push overwrites them.
   always_ff @(posedge clk) begin
      for (int i = 0; i < MAX_OUTS; i++) begin
         if (kill_ifu && tags[i].own == OWN_IFU) tags[i].kill <= 1'b1;
      end
      if (push) tags[wr_ptr] <= push_tag;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   assign head = tags[rd_ptr];

endmodule

// File: rtl/u_mem_arb.sv
// Arbitrates the single-port memory bus between IFU fetches and LSU loads/stores,
// tracks outstanding transactions in order and routes responses back to their owner.
module u_mem_arb
   import riscv_pkg::*;
#(
   parameter int MAX_OUTS   = 2,
   parameter int STARVE_LIM = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        ifu_req,
   input  logic [31:0] ifu_adr,
   output logic        ifu_gnt,
   input  logic        ifu_flush,
   output logic        ifu_vld,
   output logic [31:0] ifu_rd,
   input  logic        lsu_req,
   input  logic [31:0] lsu_a,
   input  logic [3:0]  lsu_we,
   input  logic [31:0] lsu_wd,
   input  logic [3:0]  lsu_re,
   output logic        lsu_gnt,
   output logic        lsu_vld,
   output logic [31:0] lsu_rd,
   output logic        mem_req,
   output logic [31:0] mem_a,
   output logic [3:0]  mem_we,
   output logic [31:0] mem_wd,
   output logic [3:0]  mem_re,
   input  logic        mem_gnt,
   input  logic        mem_rvld,
   input  logic [31:0] mem_rd
);

   localparam int CW = $clog2(MAX_OUTS + 1);
   localparam int SW = $clog2(STARVE_LIM + 1);

   logic [CW-1:0] cnt;
   mem_tag_t      head;
   logic          full;
   logic          empty;
   logic          sel_ifu;
   logic          sel_lsu;
   logic          push;
   logic          pop;
   logic          lock_q;
   mem_owner_e    lock_own_q;
   logic [SW-1:0] starve_q;

   assign full  = (cnt == CW'(MAX_OUTS));
   assign empty = (cnt == '0);

   // A stalled request keeps the bus until granted, so a late IFU cannot cut in.
   always_comb begin
      sel_ifu = 1'b0;
      sel_lsu = 1'b0;
      if (!full) begin
         if (lock_q) begin
            if (lock_own_q == OWN_LSU) sel_lsu = 1'b1;
            else                       sel_ifu = 1'b1;
         end else if (lsu_req && !(ifu_req && starve_q == SW'(STARVE_LIM))) begin
            sel_lsu = 1'b1;
         end else if (ifu_req) begin
            sel_ifu = 1'b1;
         end
      end
   end

   always_comb begin
      mem_req = sel_ifu | sel_lsu;
      mem_a   = '0;
      mem_we  = '0;
      mem_wd  = '0;
      mem_re  = '0;
      if (sel_lsu) begin
         mem_a  = lsu_a;
         mem_we = lsu_we;
         mem_wd = lsu_wd;
         mem_re = lsu_re;
      end else if (sel_ifu) begin
         mem_a  = ifu_adr;
         mem_re = IFU_RE;
      end
   end

   assign ifu_gnt = sel_ifu & mem_gnt;
   assign lsu_gnt = sel_lsu & mem_gnt;
   assign push    = mem_req & mem_gnt;
   assign pop     = mem_rvld & !empty;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lock_q     <= 1'b0;
         lock_own_q <= OWN_IFU;
         starve_q   <= '0;
      end else begin
         if (mem_req) begin
            lock_q     <= !mem_gnt;
            lock_own_q <= sel_lsu ? OWN_LSU : OWN_IFU;
         end
         if (!ifu_req || ifu_gnt)                 starve_q <= '0;
         else if (starve_q != SW'(STARVE_LIM))    starve_q <= starve_q + 1'b1;
      end
   end

   u_owner_fifo #(.MAX_OUTS(MAX_OUTS)) u_fifo (
      .clk      (clk),
      .rstn     (rstn),
      .push     (push),
      .push_tag ('{own: (sel_lsu ? OWN_LSU : OWN_IFU), kill: 1'b0}),
      .pop      (pop),
      .kill_ifu (ifu_flush),
      .head     (head),
      .cnt      (cnt)
   );

   // A flush also covers the fetch whose response is returning right now.
   always_comb begin
      lsu_vld = pop && head.own == OWN_LSU;
      ifu_vld = pop && head.own == OWN_IFU && !head.kill && !ifu_flush;
      lsu_rd  = lsu_vld ? mem_rd : '0;
      ifu_rd  = ifu_vld ? mem_rd : '0;
   end

`ifndef SYNTHESIS
   a_stray_rvld: assert property (@(posedge clk) disable iff (!rstn) !(mem_rvld && empty))
      else $warning("u_mem_arb: mem_rvld with no outstanding transaction");
`endif

endmodule

// File: tb/tb_u_mem_arb.sv
// Cycle-table bench for u_mem_arb with a response scoreboard of expected owners.
module tb_u_mem_arb;

   localparam int S_NONE = 0;
   localparam int S_IFU  = 1;
   localparam int S_LSU  = 2;

   logic        clk = 1'b0;
   logic        rstn;
   logic        ifu_req = 1'b0, ifu_flush = 1'b0, lsu_req = 1'b0;
   logic [31:0] ifu_adr = '0, lsu_a = '0, lsu_wd = '0, mem_rd = '0;
   logic [3:0]  lsu_we = '0, lsu_re = '0;
   logic        mem_gnt = 1'b0, mem_rvld = 1'b0;
   logic        ifu_gnt, ifu_vld, lsu_gnt, lsu_vld, mem_req;
   logic [31:0] ifu_rd, lsu_rd, mem_a, mem_wd;
   logic [3:0]  mem_we, mem_re;

   always #5 clk = ~clk;

   u_mem_arb #(.MAX_OUTS(2), .STARVE_LIM(4)) dut (
      .clk(clk), .rstn(rstn),
      .ifu_req(ifu_req), .ifu_adr(ifu_adr), .ifu_gnt(ifu_gnt), .ifu_flush(ifu_flush),
      .ifu_vld(ifu_vld), .ifu_rd(ifu_rd),
      .lsu_req(lsu_req), .lsu_a(lsu_a), .lsu_we(lsu_we), .lsu_wd(lsu_wd), .lsu_re(lsu_re),
      .lsu_gnt(lsu_gnt), .lsu_vld(lsu_vld), .lsu_rd(lsu_rd),
      .mem_req(mem_req), .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_re(mem_re),
      .mem_gnt(mem_gnt), .mem_rvld(mem_rvld), .mem_rd(mem_rd)
   );

   typedef struct {
      logic lsu;
      logic kill;
   } sb_t;

   typedef struct {
      logic        ir, lr, mg, fl, rv;
      logic [31:0] rd;
      int          esel;
   } vec_t;

   sb_t  sb[$];
   vec_t tbl[$];
   int   n_chk = 0;
   int   n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask

   function automatic void add(input logic ir, lr, mg, fl, rv, input logic [31:0] rd,
                               input int esel);
      vec_t v;
      v.ir = ir; v.lr = lr; v.mg = mg; v.fl = fl; v.rv = rv; v.rd = rd; v.esel = esel;
      tbl.push_back(v);
   endfunction

   task automatic step(input vec_t v, input string tag);
      sb_t         e;
      logic        exp_iv, exp_lv;
      logic [31:0] ea, ewd;
      logic [3:0]  ewe, ere;
      @(negedge clk);
      ifu_req = v.ir; lsu_req = v.lr; mem_gnt = v.mg; ifu_flush = v.fl;
      mem_rvld = v.rv; mem_rd = v.rd;
      #1;
      ea = '0; ewe = '0; ewd = '0; ere = '0;
      if (v.esel == S_LSU) begin
         ea = lsu_a; ewe = lsu_we; ewd = lsu_wd; ere = lsu_re;
      end else if (v.esel == S_IFU) begin
         ea = ifu_adr; ere = 4'hF;
      end
      chk({tag, ".mem_req"}, 32'(mem_req), 32'(v.esel != S_NONE));
      chk({tag, ".ifu_gnt"}, 32'(ifu_gnt), 32'(v.esel == S_IFU && v.mg));
      chk({tag, ".lsu_gnt"}, 32'(lsu_gnt), 32'(v.esel == S_LSU && v.mg));
      chk({tag, ".mem_a"},   mem_a, ea);
      chk({tag, ".mem_we"},  32'(mem_we), 32'(ewe));
      chk({tag, ".mem_wd"},  mem_wd, ewd);
      chk({tag, ".mem_re"},  32'(mem_re), 32'(ere));
      exp_iv = 1'b0;
      exp_lv = 1'b0;
      if (v.rv && sb.size() > 0) begin
         e = sb.pop_front();
         exp_lv = e.lsu;
         exp_iv = !e.lsu && !e.kill && !v.fl;
      end
      chk({tag, ".ifu_vld"}, 32'(ifu_vld), 32'(exp_iv));
      chk({tag, ".ifu_rd"},  ifu_rd, exp_iv ? v.rd : 32'h0);
      chk({tag, ".lsu_vld"}, 32'(lsu_vld), 32'(exp_lv));
      chk({tag, ".lsu_rd"},  lsu_rd, exp_lv ? v.rd : 32'h0);
      if (v.fl) begin
         foreach (sb[i]) if (!sb[i].lsu) sb[i].kill = 1'b1;
      end
      if (v.mg && v.esel != S_NONE) begin
         e.lsu = (v.esel == S_LSU);
         e.kill = 1'b0;
         sb.push_back(e);
      end
   endtask

   task automatic run_tbl(input string name);
      foreach (tbl[i]) step(tbl[i], $sformatf("%s[%0d]", name, i));
      tbl.delete();
   endtask

   task automatic chk_idle(input string name);
      chk({name, ".mem_req"}, 32'(mem_req), 32'h0);
      chk({name, ".ifu_gnt"}, 32'(ifu_gnt), 32'h0);
      chk({name, ".lsu_gnt"}, 32'(lsu_gnt), 32'h0);
      chk({name, ".ifu_vld"}, 32'(ifu_vld), 32'h0);
      chk({name, ".lsu_vld"}, 32'(lsu_vld), 32'h0);
      chk({name, ".ifu_rd"},  ifu_rd, 32'h0);
      chk({name, ".lsu_rd"},  lsu_rd, 32'h0);
      chk({name, ".mem_a"},   mem_a, 32'h0);
      chk({name, ".mem_re"},  32'(mem_re), 32'h0);
   endtask

   initial begin
      rstn = 1'b0;
      #12;
      chk_idle("reset");
      @(negedge clk);
      rstn = 1'b1;

      // IFU-only fetch, response one cycle later
      ifu_adr = 32'h0000_0080;
      add(1, 0, 1, 0, 0, 32'h0, S_IFU);
      add(0, 0, 0, 0, 1, 32'h0000_0013, S_NONE);
      run_tbl("ifu_only");

      // Both requesting: LSU x4, starving IFU wins once, then LSU
      ifu_adr = 32'h0000_0084; lsu_a = 32'h0000_0200; lsu_we = 4'h0; lsu_wd = '0; lsu_re = 4'hF;
      add(1, 1, 1, 0, 0, 32'h0, S_LSU);
      for (int i = 1; i <= 3; i++) add(1, 1, 1, 0, 1, 32'h1000 + i, S_LSU);
      add(1, 1, 1, 0, 1, 32'h1004, S_IFU);
      add(1, 1, 1, 0, 1, 32'h1005, S_LSU);
      add(0, 0, 0, 0, 1, 32'h1006, S_NONE);
      run_tbl("starve");

      // Stalled store holds the bus while IFU arrives
      ifu_adr = 32'h0000_0088; lsu_a = 32'h0000_0100; lsu_we = 4'hF;
      lsu_wd = 32'hDEAD_BEEF; lsu_re = 4'h0;
      for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 32'h0, S_LSU);
      add(1, 1, 0, 0, 0, 32'h0, S_LSU);
      add(1, 1, 1, 0, 0, 32'h0, S_LSU);
      add(1, 0, 1, 0, 1, 32'h0000_00AA, S_IFU);
      add(0, 0, 0, 0, 1, 32'h0000_2002, S_NONE);
      run_tbl("lock");

      // Flush kills in-flight fetches; a fetch accepted during flush survives
      ifu_adr = 32'h0000_0090;
      add(1, 0, 1, 0, 0, 32'h0, S_IFU);
      add(1, 0, 1, 0, 0, 32'h0, S_IFU);
      add(0, 0, 0, 1, 0, 32'h0, S_NONE);
      add(0, 0, 0, 0, 1, 32'h77, S_NONE);
      add(0, 0, 0, 0, 1, 32'h78, S_NONE);
      add(1, 0, 1, 0, 0, 32'h0, S_IFU);
      add(1, 0, 1, 1, 1, 32'h79, S_IFU);
      add(0, 0, 0, 0, 1, 32'h7A, S_NONE);
      run_tbl("flush");

      // Occupancy limit blocks requests until a response frees a slot
      ifu_adr = 32'h0000_00A0; lsu_a = 32'h0000_0300; lsu_we = 4'h0; lsu_wd = '0; lsu_re = 4'h3;
      add(1, 0, 1, 0, 0, 32'h0, S_IFU);
      add(0, 1, 1, 0, 0, 32'h0, S_LSU);
      add(1, 1, 1, 0, 0, 32'h0, S_NONE);
      add(1, 1, 1, 0, 1, 32'h31, S_NONE);
      add(1, 1, 1, 0, 0, 32'h0, S_LSU);
      add(0, 0, 0, 0, 1, 32'h32, S_NONE);
      add(0, 0, 0, 0, 1, 32'h33, S_NONE);
      run_tbl("full");

      // Reset with two outstanding, then a stray response
      add(1, 0, 1, 0, 0, 32'h0, S_IFU);
      add(0, 1, 1, 0, 0, 32'h0, S_LSU);
      run_tbl("pre_rst");
      ifu_req = 1'b0; lsu_req = 1'b0; mem_gnt = 1'b0; ifu_flush = 1'b0;
      mem_rvld = 1'b1; mem_rd = 32'h44;
      rstn = 1'b0;
      #1;
      chk_idle("in_rst");
      @(negedge clk);
      mem_rvld = 1'b0;
      rstn = 1'b1;
      sb.delete();
      add(0, 0, 0, 0, 1, 32'h55, S_NONE);
      add(1, 0, 1, 0, 0, 32'h0, S_IFU);
      add(0, 1, 1, 0, 0, 32'h0, S_LSU);
      add(0, 0, 0, 0, 1, 32'h56, S_NONE);
      add(0, 0, 0, 0, 1, 32'h57, S_NONE);
      run_tbl("post_rst");

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
